// File: rtl/i2c_xfer_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2c_xfer_seq_if                                                      |
// | Host request/data streams and i2c_master register bus for the        |
// | transaction sequencer.                                               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface i2c_xfer_seq_if;
    logic       req_valid;
    logic       req_ready;
    logic [6:0] req_sla;
    logic       req_rd;
    logic [3:0] req_len;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic       done;
    logic [1:0] err;
    logic [7:0] i2ccr;
    logic [7:0] i2cdr;
    logic       txrx_done;
    logic [7:0] i2csr;
    logic [7:0] i2crxdr;

    // slave: the sequencer itself; master: host logic plus i2c_master side
    modport slave (
        input  req_valid, req_sla, req_rd, req_len, wr_data, wr_valid, rd_ready, i2csr, i2crxdr,
        output req_ready, wr_ready, rd_data, rd_valid, done, err, i2ccr, i2cdr, txrx_done
    );
    modport master (
        output req_valid, req_sla, req_rd, req_len, wr_data, wr_valid, rd_ready, i2csr, i2crxdr,
        input  req_ready, wr_ready, rd_data, rd_valid, done, err, i2ccr, i2cdr, txrx_done
    );
endinterface
`default_nettype wire

// File: rtl/i2c_xfer_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2c_xfer_seq                                                         |
// | Sequences one I2C transaction over the i2c_master register bus,      |
// | with a write byte stream in and a FIFO-buffered read stream out.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module i2c_xfer_seq #(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 65535
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    i2c_xfer_seq_if.slave bus
);
    localparam int          AW          = $clog2(FIFO_DEPTH);
    localparam logic [15:0] c_tmo_limit = 16'(TIMEOUT);
    localparam logic [7:0]  c_cr_idle   = 8'h80;
    localparam logic [7:0]  c_cr_wr     = 8'hB0;
    localparam logic [7:0]  c_cr_rd     = 8'hA0;
    localparam logic [7:0]  c_cr_rd_nak = 8'hA8;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_WAIT_ADDR, S_WR_LOAD, S_WR_GO,
        S_WR_WAIT, S_RD_SETUP, S_RD_WAIT, S_RD_PUSH, S_STOP
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_sr_meta, r_sr_sync;   // {MCF, MAL, RXAK}
    logic        r_mcf_prev;
    logic        r_rd,   w_rd;
    logic [3:0]  r_cnt,  w_cnt;
    logic [7:0]  r_ccr,  w_ccr;
    logic [7:0]  r_dr,   w_dr;
    logic        r_txrx, w_txrx;
    logic        r_done, w_done;
    logic [1:0]  r_err,  w_err;
    logic [7:0]  r_rxb,  w_rxb;
    logic [15:0] r_tmo;
    logic        w_push, w_pop, w_stop;
    logic [1:0]  w_stop_err;
    logic        w_evt, w_mal, w_rxak, w_in_wait, w_tmo_hit;
    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wp, r_rp;
    logic        w_full, w_empty;

    assign w_evt     = r_sr_sync[2] & ~r_mcf_prev;
    assign w_mal     = r_sr_sync[1];
    assign w_rxak    = r_sr_sync[0];
    assign w_in_wait = (r_state == S_WAIT_ADDR) || (r_state == S_WR_WAIT) || (r_state == S_RD_WAIT);
    assign w_tmo_hit = (r_tmo == c_tmo_limit);

    assign w_empty = (r_wp == r_rp);
    assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_pop   = !w_empty && bus.rd_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_rd        = r_rd;
        w_cnt       = r_cnt;
        w_ccr       = r_ccr;
        w_dr        = r_dr;
        w_txrx      = 1'b0;
        w_done      = 1'b0;
        w_err       = r_err;
        w_rxb       = r_rxb;
        w_push      = 1'b0;
        w_stop      = 1'b0;
        w_stop_err  = 2'd0;
        case (r_state)
            S_IDLE: begin
                w_ccr = c_cr_idle;
                if (bus.req_valid) begin
                    w_rd        = bus.req_rd;
                    w_cnt       = bus.req_len;
                    w_dr        = {bus.req_sla, bus.req_rd};
                    w_ccr       = c_cr_wr;
                    w_state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                w_txrx      = 1'b1;
                w_state_nxt = S_WAIT_ADDR;
            end
            S_WAIT_ADDR: begin
                if (w_evt) begin
                    if (w_mal)              begin w_stop = 1'b1; w_stop_err = 2'd2; end
                    else if (w_rxak)        begin w_stop = 1'b1; w_stop_err = 2'd1; end
                    else if (r_cnt == 4'd0) begin w_stop = 1'b1; w_stop_err = 2'd0; end
                    else if (r_rd) begin
                        w_ccr       = (r_cnt == 4'd1) ? c_cr_rd_nak : c_cr_rd;
                        w_state_nxt = S_RD_SETUP;
                    end else begin
                        w_state_nxt = S_WR_LOAD;
                    end
                end else if (w_tmo_hit) begin
                    w_stop = 1'b1; w_stop_err = 2'd3;
                end
            end
            S_WR_LOAD: begin
                if (bus.wr_valid) begin
                    w_dr        = bus.wr_data;
                    w_cnt       = r_cnt - 4'd1;
                    w_state_nxt = S_WR_GO;
                end
            end
            S_WR_GO: begin
                w_txrx      = 1'b1;
                w_state_nxt = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (w_evt) begin
                    if (w_mal)              begin w_stop = 1'b1; w_stop_err = 2'd2; end
                    else if (w_rxak)        begin w_stop = 1'b1; w_stop_err = 2'd1; end
                    else if (r_cnt == 4'd0) begin w_stop = 1'b1; w_stop_err = 2'd0; end
                    else                    w_state_nxt = S_WR_LOAD;
                end else if (w_tmo_hit) begin
                    w_stop = 1'b1; w_stop_err = 2'd3;
                end
            end
            S_RD_SETUP: begin
                w_txrx      = 1'b1;
                w_state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (w_evt) begin
                    if (w_mal) begin
                        w_stop = 1'b1; w_stop_err = 2'd2;
                    end else begin
                        w_rxb       = bus.i2crxdr;
                        w_state_nxt = S_RD_PUSH;
                    end
                end else if (w_tmo_hit) begin
                    w_stop = 1'b1; w_stop_err = 2'd3;
                end
            end
            S_RD_PUSH: begin
                // Stalling here leaves MCF set, so the master stretches SCL
                if (!w_full) begin
                    w_push = 1'b1;
                    w_cnt  = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_stop = 1'b1; w_stop_err = 2'd0;
                    end else begin
                        w_ccr       = (r_cnt == 4'd2) ? c_cr_rd_nak : c_cr_rd;
                        w_state_nxt = S_RD_SETUP;
                    end
                end
            end
            S_STOP: begin
                w_txrx      = 1'b1;
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_stop) begin
            w_state_nxt = S_STOP;
            w_ccr       = c_cr_idle;
            w_err       = w_stop_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_sr_meta  <= 3'b000;
            r_sr_sync  <= 3'b000;
            r_mcf_prev <= 1'b0;
            r_rd       <= 1'b0;
            r_cnt      <= 4'd0;
            r_ccr      <= 8'h00;
            r_dr       <= 8'hFF;
            r_txrx     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 2'd0;
            r_rxb      <= 8'h00;
            r_tmo      <= 16'd0;
            r_wp       <= '0;
            r_rp       <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_sr_meta  <= {bus.i2csr[7], bus.i2csr[4], bus.i2csr[0]};
            r_sr_sync  <= r_sr_meta;
            r_mcf_prev <= r_sr_sync[2];
            r_rd       <= w_rd;
            r_cnt      <= w_cnt;
            r_ccr      <= w_ccr;
            r_dr       <= w_dr;
            r_txrx     <= w_txrx;
            r_done     <= w_done;
            r_err      <= w_err;
            r_rxb      <= w_rxb;
            r_tmo      <= w_in_wait ? r_tmo + 16'd1 : 16'd0;
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp[AW-1:0]] <= r_rxb;
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.wr_ready  = (r_state == S_WR_LOAD);
    assign bus.rd_valid  = !w_empty;
    assign bus.rd_data   = w_empty ? 8'h00 : r_mem[r_rp[AW-1:0]];
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.i2ccr     = r_ccr;
    assign bus.i2cdr     = r_dr;
    assign bus.txrx_done = r_txrx;
endmodule
`default_nettype wire

// File: tb/tb_i2c_xfer_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_i2c_xfer_seq                                                      |
// | Directed and random transactions against a behavioural I2C master.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_i2c_xfer_seq;
    localparam int FIFO_DEPTH = 2;
    localparam int TIMEOUT    = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2c_xfer_seq_if bus ();

    i2c_xfer_seq #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic       hang;
        logic       mal;
        logic       rxak;
        logic [7:0] rx;
    } resp_t;

    resp_t       resp_q[$];
    logic [15:0] seen_log[$];   // {i2ccr, i2cdr} at each txrx_done pulse
    logic [7:0]  got_rd[$];
    resp_t       script [0:15]; // index 0 = address byte, k = data byte k
    logic [7:0]  wdata  [0:15];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_viol  = 0;
    logic        prev_tx = 1'b0;
    logic        prev_dn = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural i2c_master: clears MCF on each handed-over byte, then completes it
    initial begin
        resp_t r;
        int    dly;
        bit    busy;
        busy = 0; dly = 0; r = '0;
        bus.i2csr   = 8'h00;
        bus.i2crxdr = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.i2csr = 8'h00;
                busy      = 0;
            end else if (bus.txrx_done) begin
                bus.i2csr = 8'h00;
                busy      = 0;
                if (bus.i2ccr[5] && resp_q.size() > 0) begin
                    r    = resp_q.pop_front();
                    dly  = 3 + $urandom_range(4);
                    busy = 1;
                end
            end else if (busy) begin
                if (dly == 0) begin
                    if (!r.hang) begin
                        bus.i2crxdr = r.rx;
                        bus.i2csr   = {1'b1, 1'b0, 1'b1, r.mal, 3'b000, r.rxak};
                    end
                    busy = 0;
                end else begin
                    dly--;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.txrx_done) seen_log.push_back({bus.i2ccr, bus.i2cdr});
            if (bus.rd_valid && bus.rd_ready) got_rd.push_back(bus.rd_data);
            if ((bus.txrx_done && prev_tx) || (bus.done && prev_dn)) n_viol++;
            prev_tx = bus.txrx_done;
            prev_dn = bus.done;
        end
    end

    task automatic clear_script();
        for (int k = 0; k < 16; k++) begin
            script[k] = '0;
            wdata[k]  = 8'h00;
        end
    endtask

    task automatic run_txn(input logic [6:0] sla, input logic rd, input logic [3:0] len,
                           input bit bp, input string name);
        logic [7:0] e_ccr[$];
        logic [7:0] e_dr[$];
        bit         e_chk[$];
        logic [7:0] e_rd[$];
        logic [1:0] e_err, o_err;
        logic       o_ready;
        logic [7:0] o_ccr;
        int         wi, cyc;
        bit         fin, took;

        // Reference: walk the byte list and decide where the transaction ends
        e_err = 2'd0;
        e_ccr.push_back(8'hB0); e_dr.push_back({sla, rd}); e_chk.push_back(1);
        if (script[0].hang)      e_err = 2'd3;
        else if (script[0].mal)  e_err = 2'd2;
        else if (script[0].rxak) e_err = 2'd1;
        else begin
            for (int j = 1; j <= int'(len); j++) begin
                if (rd) begin
                    e_ccr.push_back((j == int'(len)) ? 8'hA8 : 8'hA0);
                    e_dr.push_back(8'h00); e_chk.push_back(0);
                    if (script[j].hang) begin e_err = 2'd3; break; end
                    if (script[j].mal)  begin e_err = 2'd2; break; end
                    e_rd.push_back(script[j].rx);
                end else begin
                    e_ccr.push_back(8'hB0); e_dr.push_back(wdata[j-1]); e_chk.push_back(1);
                    if (script[j].hang) begin e_err = 2'd3; break; end
                    if (script[j].mal)  begin e_err = 2'd2; break; end
                    if (script[j].rxak) begin e_err = 2'd1; break; end
                end
            end
        end
        e_ccr.push_back(8'h80); e_dr.push_back(8'h00); e_chk.push_back(0);

        resp_q.delete();
        for (int k = 0; k <= int'(len); k++) resp_q.push_back(script[k]);
        seen_log.delete();
        got_rd.delete();
        chk({name, " req_ready_idle"}, bus.req_ready, 1);
        bus.rd_ready  = !bp;
        bus.wr_valid  = 1'b0;
        bus.req_sla   = sla;
        bus.req_rd    = rd;
        bus.req_len   = len;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;

        wi = 0; cyc = 0; fin = 0; o_err = 2'd0; o_ready = 1'b0; o_ccr = 8'h00;
        while (!fin && cyc < 3000) begin
            @(negedge clk);
            took = bus.wr_valid && bus.wr_ready;
            if (bus.done) begin
                fin = 1; o_err = bus.err; o_ready = bus.req_ready; o_ccr = bus.i2ccr;
            end
            if (bp && cyc == 150) begin
                chk({name, " stall_pulses"}, seen_log.size(), 4);
                chk({name, " stall_rd_valid"}, bus.rd_valid, 1);
                chk({name, " stall_no_pop"}, got_rd.size(), 0);
                chk({name, " stall_not_done"}, bus.done, 0);
            end
            @(posedge clk); #1;
            cyc++;
            if (took) wi++;
            bus.wr_valid = (wi < int'(len)) && !rd && ($urandom_range(3) != 0);
            bus.wr_data  = wdata[wi];
            bus.rd_ready = bp ? (cyc > 150) : ($urandom_range(3) != 0);
        end
        bus.wr_valid = 1'b0;
        if (!fin) chk({name, " done_seen"}, 0, 1);

        chk({name, " err"}, o_err, e_err);
        chk({name, " ready_at_done"}, o_ready, 1);
        chk({name, " ccr_at_done"}, o_ccr, 8'h80);
        chk({name, " pulse_count"}, seen_log.size(), e_ccr.size());
        for (int i = 0; i < e_ccr.size() && i < seen_log.size(); i++) begin
            chk($sformatf("%s ccr[%0d]", name, i), seen_log[i][15:8], e_ccr[i]);
            if (e_chk[i]) chk($sformatf("%s dr[%0d]", name, i), seen_log[i][7:0], e_dr[i]);
        end

        bus.rd_ready = 1'b1;
        repeat (FIFO_DEPTH + 4) @(posedge clk);
        #1;
        chk({name, " fifo_drained"}, bus.rd_valid, 0);
        chk({name, " rd_count"}, got_rd.size(), e_rd.size());
        for (int i = 0; i < e_rd.size() && i < got_rd.size(); i++)
            chk($sformatf("%s rd[%0d]", name, i), got_rd[i], e_rd[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bus.req_valid = 1'b0; bus.req_sla = '0; bus.req_rd = 1'b0; bus.req_len = '0;
        bus.wr_data = 8'h00; bus.wr_valid = 1'b0; bus.rd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst req_ready", bus.req_ready, 1);
        chk("rst wr_ready", bus.wr_ready, 0);
        chk("rst rd_valid", bus.rd_valid, 0);
        chk("rst rd_data", bus.rd_data, 8'h00);
        chk("rst done", bus.done, 0);
        chk("rst err", bus.err, 0);
        chk("rst i2ccr", bus.i2ccr, 8'h00);
        chk("rst i2cdr", bus.i2cdr, 8'hFF);
        chk("rst txrx", bus.txrx_done, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle i2ccr", bus.i2ccr, 8'h80);

        clear_script(); wdata[0] = 8'h12; wdata[1] = 8'h34;
        run_txn(7'h50, 1'b0, 4'd2, 0, "write");

        clear_script(); script[1].rx = 8'hAA; script[2].rx = 8'hBB; script[3].rx = 8'hCC;
        run_txn(7'h50, 1'b1, 4'd3, 0, "read");

        clear_script(); script[0].rxak = 1'b1;
        run_txn(7'h3C, 1'b0, 4'd0, 0, "probe_nack");

        clear_script();
        run_txn(7'h3C, 1'b1, 4'd0, 0, "probe_ack");

        clear_script();
        script[1].rx = 8'h11; script[2].rx = 8'h22; script[3].rx = 8'h33; script[4].rx = 8'h44;
        run_txn(7'h50, 1'b1, 4'd4, 1, "backpressure");

        clear_script(); wdata[0] = 8'hDE; wdata[1] = 8'hAD; wdata[2] = 8'hBE; script[2].mal = 1'b1;
        run_txn(7'h50, 1'b0, 4'd3, 0, "arb_lost");

        clear_script(); script[0].hang = 1'b1;
        run_txn(7'h21, 1'b1, 4'd2, 0, "timeout");

        clear_script(); wdata[0] = 8'h5A; script[1].mal = 1'b1; script[1].rxak = 1'b1;
        run_txn(7'h44, 1'b0, 4'd1, 0, "mal_over_rxak");

        // Reset while the second read byte is in flight
        clear_script(); script[1].rx = 8'h77; script[2].rx = 8'h88; script[3].rx = 8'h99;
        resp_q.delete();
        for (int k = 0; k <= 3; k++) resp_q.push_back(script[k]);
        seen_log.delete(); got_rd.delete();
        bus.rd_ready = 1'b0;
        bus.req_sla = 7'h50; bus.req_rd = 1'b1; bus.req_len = 4'd3; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        ok = 0;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            if (seen_log.size() >= 3) ok = 1;
        end
        chk("midrst reached_rd_wait", ok, 1);
        @(posedge clk); #1;
        chk("midrst fifo_before", bus.rd_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst req_ready", bus.req_ready, 1);
        chk("midrst rd_valid", bus.rd_valid, 0);
        chk("midrst rd_data", bus.rd_data, 8'h00);
        chk("midrst i2ccr", bus.i2ccr, 8'h00);
        chk("midrst i2cdr", bus.i2cdr, 8'hFF);
        chk("midrst txrx", bus.txrx_done, 0);
        chk("midrst wr_ready", bus.wr_ready, 0);
        chk("midrst done", bus.done, 0);
        @(posedge clk); #1;
        resp_q.delete();
        rst_n = 1'b1;
        bus.rd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst fifo_after", bus.rd_valid, 0);
        chk("midrst ccr_after", bus.i2ccr, 8'h80);

        for (int t = 0; t < 30; t++) begin
            logic [3:0] len_r;
            len_r = 4'($urandom_range(5));
            for (int k = 0; k < 16; k++) begin
                script[k].hang = ($urandom_range(40) == 0);
                script[k].mal  = ($urandom_range(15) == 0);
                script[k].rxak = ($urandom_range(9) == 0);
                script[k].rx   = 8'($urandom);
                wdata[k]       = 8'($urandom);
            end
            run_txn(7'($urandom), 1'($urandom_range(1)), len_r, 0, $sformatf("rnd%0d", t));
        end

        chk("pulse_width_violations", n_viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/i2c_xfer_seq.md
# i2c_xfer_seq

Transaction sequencer for the I2C byte master. It accepts one transaction request at a time: slave address, direction and length. It then drives the master's control and data registers byte by byte, pulses `I_TXRX_DONE` to hand each byte over, and watches `I2CSR` for completion, acknowledge and arbitration status. Write data streams in through a valid/ready port. Read data is buffered in a small FIFO and streamed out. It sits between the host bus logic and `i2c_master`, replacing direct software register pokes.

## Interface
- `FIFO_DEPTH`, 8, read-data FIFO depth; power of two, at least 2.
- `TIMEOUT`, 65535, max `I_CLK` cycles to wait for one MCF edge.
- `I_CLK` in 1: system clock, same clock as `i2c_master`.
- `I_RSTN` in 1: reset, asynchronous, active-low.
- `I_REQ_VALID` in 1: transaction request.
- `O_REQ_READY` out 1: sequencer idle; request accepted when valid && ready.
- `I_REQ_SLA` in 7: 7-bit slave address.
- `I_REQ_RD` in 1: direction, 1 = read, 0 = write.
- `I_REQ_LEN` in 4: data byte count; 0 = address-only probe.
- `I_WR_DATA` in 8, `I_WR_VALID` in 1, `O_WR_READY` out 1: write byte stream.
- `O_RD_DATA` out 8, `O_RD_VALID` out 1, `I_RD_READY` in 1: read byte stream, FIFO output.
- `O_DONE` out 1: one-cycle pulse at end of transaction.
- `O_ERR` out 2: status, valid with `O_DONE`. 0 = ok, 1 = NACK, 2 = arbitration lost, 3 = timeout.
- `O_I2CCR` out 8: control register to the master. Bits: MEN[7], MIEN[6], MSTA[5], MTX[4], TXAK[3], RSTA[2].
- `O_I2CDR` out 8: data register to the master.
- `O_TXRX_DONE` out 1: one-cycle pulse; hands the current byte to the master and clears MCF.
- `I_I2CSR` in 8: master status. Bits: MCF[7], MBB[5], MAL[4], RXAK[0].
- `I_I2CRXDR` in 8: byte received by the master.

## Operation
- **Synchronisation:** `I_I2CSR` is double-flopped. A "byte event" is the rising edge of synchronised MCF.
- **IDLE**
  - `O_REQ_READY`=1 and `O_I2CCR`=0x80 (MEN only).
  - On accept: latch SLA, RD and LEN; go to ADDR.
- **ADDR**
  - `O_I2CDR`={SLA,RD}; `O_I2CCR`=0xB0 (MEN|MSTA|MTX).
  - Pulse `O_TXRX_DONE`, then go to WAIT_ADDR.
- **WAIT_ADDR**, on byte event:
  - MAL=1 -> ERR=2, go to STOP.
  - RXAK=1 -> ERR=1, go to STOP.
  - LEN=0 -> ERR=0, go to STOP.
  - RD=1 -> RD_SETUP; otherwise -> WR_LOAD.
- **WR_LOAD**
  - `O_WR_READY`=1.
  - On `I_WR_VALID`: load `O_I2CDR`, decrement the remaining count, pulse `O_TXRX_DONE`, go to WR_WAIT.
  - No timeout while waiting for the host.
- **WR_WAIT**, on byte event:
  - MAL -> ERR=2, STOP.
  - RXAK -> ERR=1, STOP. The byte is still counted as sent.
  - Remaining count = 0 -> STOP; otherwise -> WR_LOAD.
- **RD_SETUP**
  - `O_I2CCR`=0xA0 (MTX cleared). TXAK=1 (0xA8) when the remaining count is 1, so the last byte is NACKed.
  - Pulse `O_TXRX_DONE`, go to RD_WAIT.
- **RD_WAIT**, on byte event:
  - MAL -> ERR=2, STOP.
  - Otherwise capture `I_I2CRXDR` and go to RD_PUSH.
- **RD_PUSH**
  - Waits while the FIFO is full; the master holds SCL because MCF is not yet cleared.
  - When not full: push the byte and decrement the count.
  - Count = 0 -> STOP; otherwise -> RD_SETUP.
- **STOP**
  - `O_I2CCR`=0x80 (MSTA cleared, generates STOP). Pulse `O_TXRX_DONE`.
  - Pulse `O_DONE` with `O_ERR`, return to IDLE.
- **Timeout:** each WAIT state has a 16-bit counter that resets on entry. When it reaches `TIMEOUT`: ERR=3, go to STOP.
- **Read FIFO**
  - Pointers are log2(`FIFO_DEPTH`)+1 bits wide.
  - Full = MSBs differ and the rest are equal; empty = pointers equal.
  - `O_RD_VALID` = !empty. Push and pop in the same cycle are both legal when not empty.
  - The FIFO is not flushed between transactions.

## Timing
- **Reset values:**
  - `O_REQ_READY`=1, `O_WR_READY`=0, `O_RD_VALID`=0, `O_RD_DATA`=0.
  - `O_DONE`=0, `O_ERR`=0, `O_I2CCR`=0x00, `O_I2CDR`=0xFF, `O_TXRX_DONE`=0.
  - State is IDLE and the FIFO is empty. `O_I2CCR` becomes 0x80 on the first clock after reset release.
- **Request:** accept-to-ADDR is 1 cycle. `O_TXRX_DONE` rises the cycle after `O_I2CDR`/`O_I2CCR` settle, so the master always sees stable registers.
- **Byte event latency:** MCF rise to state action is 3 cycles (2 sync + 1 edge detect).
- **`O_TXRX_DONE`** is never high for 2 consecutive cycles.
- **Simultaneous events:** MAL takes priority over RXAK, and RXAK over timeout.
- **`O_DONE`** is high exactly 1 cycle. `O_REQ_READY` rises in the same cycle.
- **Reset mid-transaction:** returns to IDLE immediately and the FIFO is cleared. No STOP is generated; the master is reset by the same `I_RSTN`.

## Test plan
- **Write:** SLA=0x50, RD=0, LEN=2, data 0x12/0x34, slave ACKs all. Expect `O_I2CDR` sequence 0xA0, 0x12, 0x34; 4 `O_TXRX_DONE` pulses; `O_DONE` with ERR=0.
- **Read:** SLA=0x50, RD=1, LEN=3, slave returns 0xAA/0xBB/0xCC. Expect FIFO output in that order; TXAK=1 only on the third RD_SETUP; ERR=0.
- **Probe NACK:** LEN=0, RXAK=1 on the address byte. Expect ERR=1, no data phase, `O_I2CCR` ends at 0x80.
- **Read backpressure:** FIFO_DEPTH=2, LEN=4, `I_RD_READY`=0. Expect a stall in RD_PUSH after 2 bytes with no `O_TXRX_DONE`. Release ready: all 4 bytes delivered, ERR=0.
- **Arbitration and timeout:** MAL=1 at the second write byte -> ERR=2. MCF held low for `TIMEOUT` cycles -> ERR=3. Both return to IDLE with `O_REQ_READY`=1.
- **Reset mid-read:** assert `I_RSTN` low in RD_WAIT. Outputs go to reset values in the same cycle; the FIFO is empty afterwards.
